// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter that shares one I2C master between NUM_REQ requesters.
// Each requester offers a level request plus a command (read/addr/reg/wdata).
// The winner's command is latched and handed to the master. Completion status
// is returned with a one-hot done pulse. A per-transfer timeout aborts hung
// transfers, and the arbiter then drains the master before granting again.
module i2c_master_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 20000
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ-1:0]     read_i,
    input  logic [8*NUM_REQ-1:0]   addr_i,
    input  logic [8*NUM_REQ-1:0]   reg_i,
    input  logic [8*NUM_REQ-1:0]   wdata_i,
    output logic [NUM_REQ-1:0]     gnt_o,
    output logic [NUM_REQ-1:0]     done_o,
    output logic [7:0]             rdata_o,
    output logic                   err_o,
    output logic                   timeout_o,
    output logic                   m_start_o,
    output logic                   m_read_o,
    output logic [7:0]             m_addr_o,
    output logic [7:0]             m_reg_o,
    output logic [7:0]             m_data_o,
    input  logic                   m_ready_i,
    input  logic                   m_error_i,
    input  logic [7:0]             m_data_i
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LAUNCH   = 3'd1,
        WAIT_LOW = 3'd2,
        BUSY     = 3'd3,
        DONE     = 3'd4,
        FLUSH    = 3'd5
    } state_t;

    state_t              r_state, w_next;
    logic [PW-1:0]       r_ptr;
    logic [PW-1:0]       r_own;
    logic [CW-1:0]       r_cnt;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_done;
    logic [7:0]          r_rdata;
    logic                r_err;
    logic                r_to;
    logic                r_start;
    logic                r_read;
    logic [7:0]          r_addr;
    logic [7:0]          r_reg;
    logic [7:0]          r_data;

    logic                w_found;
    logic [PW-1:0]       w_win;
    logic [PW-1:0]       w_idx;
    logic                w_grant;
    logic                w_active;
    logic                w_finish;
    logic                w_abort;
    logic [NUM_REQ-1:0]  w_one;

    assign w_one = {{(NUM_REQ-1){1'b0}}, 1'b1};

    // Round-robin search: first active request at or after r_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = PW'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_found && req_i[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_grant  = (r_state == IDLE) && w_found && m_ready_i;
    assign w_active = (r_state == WAIT_LOW) || (r_state == BUSY);
    // A genuine completion wins over a timeout that expires in the same cycle.
    assign w_finish = (r_state == BUSY) && m_ready_i;
    assign w_abort  = w_active && !w_finish && (r_cnt == CW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_grant) w_next = LAUNCH;
            LAUNCH:   w_next = WAIT_LOW;
            WAIT_LOW: begin
                if (w_abort)         w_next = DONE;
                else if (!m_ready_i) w_next = BUSY;
            end
            BUSY:     if (w_finish || w_abort) w_next = DONE;
            // After an abort the master may still be mid-transfer; drain it.
            DONE:     w_next = r_to ? FLUSH : IDLE;
            FLUSH:    if (m_ready_i) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Grant, command latch and round-robin pointer update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_gnt  <= '0;
            r_own  <= '0;
            r_ptr  <= '0;
            r_read <= 1'b0;
            r_addr <= '0;
            r_reg  <= '0;
            r_data <= '0;
        end else begin
            r_gnt <= '0;
            if (w_grant) begin
                r_gnt  <= w_one << w_win;
                r_own  <= w_win;
                r_ptr  <= (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
                r_read <= read_i[w_win];
                r_addr <= addr_i[{w_win, 3'b000} +: 8];
                r_reg  <= reg_i[{w_win, 3'b000} +: 8];
                r_data <= wdata_i[{w_win, 3'b000} +: 8];
            end
        end
    end

    // Start pulse follows the LAUNCH cycle; timeout counter runs while the
    // master owns the transfer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_start <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_start <= (r_state == LAUNCH);
            if (r_state == LAUNCH)            r_cnt <= '0;
            else if (w_active && !w_abort)    r_cnt <= r_cnt + 1'b1;
        end
    end

    // Completion status: captured on entry to DONE and held until the next one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_done  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            r_done <= '0;
            if (w_finish) begin
                r_done <= w_one << r_own;
                if (r_read) r_rdata <= m_data_i;
                r_err  <= m_error_i;
                r_to   <= 1'b0;
            end else if (w_abort) begin
                r_done <= w_one << r_own;
                r_err  <= 1'b1;
                r_to   <= 1'b1;
            end
        end
    end

    assign gnt_o     = r_gnt;
    assign done_o    = r_done;
    assign rdata_o   = r_rdata;
    assign err_o     = r_err;
    assign timeout_o = r_to;
    assign m_start_o = r_start;
    assign m_read_o  = r_read;
    assign m_addr_o  = r_addr;
    assign m_reg_o   = r_reg;
    assign m_data_o  = r_data;

endmodule
